// File: rtl/apb_protocol_monitor.sv
// APB bus-level protocol monitor. Passively watches one APB segment, tracks the
// IDLE/SETUP/WAIT phase of each transfer and reports protocol violations as a
// one-cycle pulse, a lowest-rule code, per-rule sticky flags and saturating counters.
`timescale 1ns/1ps
module apb_protocol_monitor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8,
    parameter bit STRICT_SLVERR  = 1'b1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [NUM_SLAVES-1:0] PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic                  clear,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [5:0]            err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic [1:0]            state
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0]     WCNT_ONE    = WCNT_W'(1);
    localparam logic [WCNT_W-1:0]     TIMEOUT_VAL = WCNT_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_SLAVES-1:0] PSEL_ONE    = NUM_SLAVES'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_valid_q, err_valid_d;
    logic [2:0]              err_code_q, err_code_d;
    logic [5:0]              sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0]    xfer_count_q, xfer_count_d;

    logic [5:0]              rule;
    logic                    active, abort, complete, any_err;
    logic [WCNT_W-1:0]       wait_inc;

    // Classify the current bus cycle against the tracked phase.
    always_comb begin
        active   = (state_q != ST_IDLE);
        wait_inc = wait_cnt_q + WCNT_ONE;
        rule     = '0;
        rule[0]  = |(PSEL & (PSEL - PSEL_ONE));
        rule[1]  = PENABLE && (state_q == ST_IDLE);
        rule[2]  = active && ((PSEL != psel_q) || !PENABLE);
        rule[3]  = active && ((PADDR != addr_q) || (PWRITE != write_q) ||
                              (write_q && (PWDATA != wdata_q)));
        abort    = rule[2] || rule[3];
        complete = active && !abort && PENABLE && PREADY;
        rule[4]  = (state_q == ST_WAIT) && !abort && !complete && (wait_inc == TIMEOUT_VAL);
        rule[5]  = STRICT_SLVERR && PSLVERR && !complete;
        any_err  = |rule;
    end

    // Next-state for the phase tracker and the captured setup values.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        psel_d     = psel_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if ((PSEL != '0) && !PENABLE) begin
                    state_d = ST_SETUP;
                    psel_d  = PSEL;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                end
            end
            ST_SETUP: begin
                if (abort || complete) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_ONE;
                end
            end
            ST_WAIT: begin
                if (abort || complete || rule[4]) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky flags: a new violation always lands, even when clear is asserted.
    for (genvar gi = 0; gi < 6; gi++) begin : g_sticky
        assign sticky_d[gi] = rule[gi] | (sticky_q[gi] & ~clear);
    end

    // Pulse, lowest-rule code and saturating counters; a new event beats clear.
    always_comb begin
        err_valid_d = any_err;
        err_code_d  = err_code_q;
        for (int i = 5; i >= 0; i--) begin
            if (rule[i]) err_code_d = 3'(i);
        end
        if (clear)
            err_count_d = any_err ? CNT_ONE : '0;
        else if (any_err && (err_count_q != CNT_MAX))
            err_count_d = err_count_q + CNT_ONE;
        else
            err_count_d = err_count_q;
        if (clear)
            xfer_count_d = complete ? CNT_ONE : '0;
        else if (complete && (xfer_count_q != CNT_MAX))
            xfer_count_d = xfer_count_q + CNT_ONE;
        else
            xfer_count_d = xfer_count_q;
    end

    // Single register bank for tracker state and all reported status.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            psel_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            sticky_q     <= '0;
            err_count_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            psel_q       <= psel_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            sticky_q     <= sticky_d;
            err_count_q  <= err_count_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_count_q;
    assign xfer_count = xfer_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed testbench for apb_protocol_monitor (default parameters plus a
// second instance with PSLVERR checking disabled).
`timescale 1ns/1ps
module tb_apb_protocol_monitor;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [3:0]  PSEL = '0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        clear = 1'b0;

    logic        err_valid;
    logic [2:0]  err_code;
    logic [5:0]  err_sticky;
    logic [7:0]  err_count, xfer_count;
    logic [1:0]  state;

    logic        lax_err_valid;
    logic [2:0]  lax_err_code;
    logic [5:0]  lax_err_sticky;
    logic [7:0]  lax_err_count, lax_xfer_count;
    logic [1:0]  lax_state;

    int passed = 0;
    int total  = 0;

    apb_protocol_monitor dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .clear(clear),
        .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
        .err_count(err_count), .xfer_count(xfer_count), .state(state)
    );

    apb_protocol_monitor #(.STRICT_SLVERR(1'b0)) dut_lax (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .clear(clear),
        .err_valid(lax_err_valid), .err_code(lax_err_code), .err_sticky(lax_err_sticky),
        .err_count(lax_err_count), .xfer_count(lax_xfer_count), .state(lax_state)
    );

    always #5 PCLK = ~PCLK;

    // Advance one bus cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic rdy);
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = d; PREADY = rdy;
    endtask

    task automatic bus_idle();
        drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid got %0b want 0", err_valid); else passed++;
        total++; if (err_code !== 3'd0) $display("FAIL reset_err_code got %0d want 0", err_code); else passed++;
        total++; if (err_sticky !== 6'd0) $display("FAIL reset_sticky got %b want 000000", err_sticky); else passed++;
        total++; if (err_count !== 8'd0 || xfer_count !== 8'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", err_count, xfer_count); else passed++;
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        tick(); tick();
        PRESETn = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_clean_transfers();
        int bad = 0;
        drive(4'b0001, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0); tick();
        total++; if (state !== 2'd1) $display("FAIL wr_setup_state got %0d want 1", state); else passed++;
        drive(4'b0001, 1'b1, 1'b1, 32'h10, 32'hA5A5_0001, 1'b1); tick();
        total++; if (state !== 2'd0 || xfer_count !== 8'd1) $display("FAIL wr_done state/xfer got %0d/%0d want 0/1", state, xfer_count); else passed++;
        if (err_valid !== 1'b0) bad++;
        // back-to-back read setup directly after the write completion
        drive(4'b0010, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0); tick();
        total++; if (state !== 2'd1 || err_valid !== 1'b0) $display("FAIL b2b_setup state/err got %0d/%0b want 1/0", state, err_valid); else passed++;
        drive(4'b0010, 1'b1, 1'b0, 32'h20, 32'h1111, 1'b0); tick(); if (err_valid !== 1'b0) bad++;
        drive(4'b0010, 1'b1, 1'b0, 32'h20, 32'h2222, 1'b0); tick(); if (err_valid !== 1'b0) bad++;
        total++; if (state !== 2'd2) $display("FAIL rd_wait_state got %0d want 2", state); else passed++;
        drive(4'b0010, 1'b1, 1'b0, 32'h20, 32'h3333, 1'b1); tick(); if (err_valid !== 1'b0) bad++;
        total++; if (state !== 2'd0 || xfer_count !== 8'd2) $display("FAIL rd_done state/xfer got %0d/%0d want 0/2", state, xfer_count); else passed++;
        bus_idle(); tick(); if (err_valid !== 1'b0) bad++;
        total++; if (bad != 0 || err_count !== 8'd0 || err_sticky !== 6'd0) $display("FAIL clean_no_error got bad=%0d cnt=%0d sticky=%b want 0/0/000000", bad, err_count, err_sticky); else passed++;
        $display("test_clean_transfers done");
    endtask

    task automatic test_addr_change();
        drive(4'b0001, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0); tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0); tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0); tick();
        total++; if (err_valid !== 1'b1 || err_code !== 3'd3) $display("FAIL addr_chg valid/code got %0b/%0d want 1/3", err_valid, err_code); else passed++;
        total++; if (err_sticky !== 6'b001000 || err_count !== 8'd1) $display("FAIL addr_chg sticky/cnt got %b/%0d want 001000/1", err_sticky, err_count); else passed++;
        total++; if (state !== 2'd0) $display("FAIL addr_chg_state got %0d want 0", state); else passed++;
        bus_idle(); tick();
        total++; if (err_valid !== 1'b0 || err_code !== 3'd3) $display("FAIL pulse_hold valid/code got %0b/%0d want 0/3", err_valid, err_code); else passed++;
        $display("test_addr_change done");
    endtask

    task automatic test_clear_and_timeout();
        int early = 0;
        clear = 1'b1; tick(); clear = 1'b0;
        total++; if (err_sticky !== 6'd0 || err_count !== 8'd0 || xfer_count !== 8'd0) $display("FAIL clear got %b/%0d/%0d want 000000/0/0", err_sticky, err_count, xfer_count); else passed++;
        total++; if (err_code !== 3'd3) $display("FAIL clear_keeps_code got %0d want 3", err_code); else passed++;
        drive(4'b0100, 1'b0, 1'b1, 32'h30, 32'hDEAD, 1'b0); tick();
        for (int i = 1; i <= 15; i++) begin
            drive(4'b0100, 1'b1, 1'b1, 32'h30, 32'hDEAD, 1'b0); tick();
            if (err_valid !== 1'b0) early++;
        end
        total++; if (early != 0) $display("FAIL timeout_early got %0d pulses want 0", early); else passed++;
        drive(4'b0100, 1'b1, 1'b1, 32'h30, 32'hDEAD, 1'b0); tick();
        total++; if (err_valid !== 1'b1 || err_code !== 3'd4) $display("FAIL timeout valid/code got %0b/%0d want 1/4", err_valid, err_code); else passed++;
        total++; if (err_sticky !== 6'b010000 || state !== 2'd0) $display("FAIL timeout sticky/state got %b/%0d want 010000/0", err_sticky, state); else passed++;
        bus_idle(); tick();
        total++; if (err_valid !== 1'b0 || err_count !== 8'd1) $display("FAIL timeout_single valid/cnt got %0b/%0d want 0/1", err_valid, err_count); else passed++;
        $display("test_clear_and_timeout done");
    endtask

    task automatic test_multi_rule();
        drive(4'b0101, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0); tick();
        total++; if (err_valid !== 1'b1 || err_code !== 3'd0) $display("FAIL multi valid/code got %0b/%0d want 1/0", err_valid, err_code); else passed++;
        total++; if (err_sticky !== 6'b010011 || err_count !== 8'd2) $display("FAIL multi sticky/cnt got %b/%0d want 010011/2", err_sticky, err_count); else passed++;
        bus_idle(); tick();
        $display("test_multi_rule done");
    endtask

    task automatic test_saturation();
        drive(4'b0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        total++; if (err_count !== 8'd255) $display("FAIL saturate got %0d want 255", err_count); else passed++;
        clear = 1'b1; tick(); clear = 1'b0;
        total++; if (err_count !== 8'd1 || err_sticky !== 6'b000010) $display("FAIL clear_vs_err cnt/sticky got %0d/%b want 1/000010", err_count, err_sticky); else passed++;
        total++; if (err_valid !== 1'b1 || err_code !== 3'd1) $display("FAIL clear_vs_err valid/code got %0b/%0d want 1/1", err_valid, err_code); else passed++;
        bus_idle(); tick();
        $display("test_saturation done");
    endtask

    task automatic test_reset_midxfer();
        int bad = 0;
        drive(4'b1000, 1'b0, 1'b0, 32'h50, 32'h0, 1'b0); tick();
        drive(4'b1000, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0); tick();
        total++; if (state !== 2'd2) $display("FAIL pre_reset_state got %0d want 2", state); else passed++;
        PRESETn = 1'b0; #2;
        total++; if (state !== 2'd0 || err_count !== 8'd0 || err_sticky !== 6'd0 || err_code !== 3'd0 || xfer_count !== 8'd0)
            $display("FAIL async_reset got st=%0d cnt=%0d sticky=%b code=%0d xfer=%0d want all 0", state, err_count, err_sticky, err_code, xfer_count); else passed++;
        bus_idle(); tick(); tick();
        PRESETn = 1'b1; tick();
        drive(4'b0001, 1'b0, 1'b1, 32'h60, 32'h1234, 1'b0); tick(); if (err_valid !== 1'b0) bad++;
        drive(4'b0001, 1'b1, 1'b1, 32'h60, 32'h1234, 1'b1); tick(); if (err_valid !== 1'b0) bad++;
        bus_idle(); tick(); if (err_valid !== 1'b0) bad++;
        total++; if (xfer_count !== 8'd1 || err_count !== 8'd0 || bad != 0) $display("FAIL post_reset xfer/cnt/bad got %0d/%0d/%0d want 1/0/0", xfer_count, err_count, bad); else passed++;
        $display("test_reset_midxfer done");
    endtask

    task automatic test_slverr();
        PSLVERR = 1'b1; tick(); PSLVERR = 1'b0;
        total++; if (err_valid !== 1'b1 || err_code !== 3'd5 || err_sticky !== 6'b100000) $display("FAIL slverr_strict got %0b/%0d/%b want 1/5/100000", err_valid, err_code, err_sticky); else passed++;
        total++; if (lax_err_valid !== 1'b0 || lax_err_count !== 8'd0) $display("FAIL slverr_lax got %0b/%0d want 0/0", lax_err_valid, lax_err_count); else passed++;
        tick();
        $display("test_slverr done");
    endtask

    task automatic test_back_to_back();
        drive(4'b0001, 1'b0, 1'b1, 32'h70, 32'h55, 1'b0); tick();
        drive(4'b0001, 1'b1, 1'b1, 32'h70, 32'h55, 1'b1); tick();
        total++; if (xfer_count !== 8'd2 || err_valid !== 1'b0) $display("FAIL b2b_done xfer/valid got %0d/%0b want 2/0", xfer_count, err_valid); else passed++;
        drive(4'b0001, 1'b1, 1'b1, 32'h74, 32'h66, 1'b1); tick();
        total++; if (err_valid !== 1'b1 || err_code !== 3'd1 || state !== 2'd0) $display("FAIL b2b_penable valid/code/state got %0b/%0d/%0d want 1/1/0", err_valid, err_code, state); else passed++;
        total++; if (err_sticky !== 6'b100010 || err_count !== 8'd2) $display("FAIL b2b_sticky/cnt got %b/%0d want 100010/2", err_sticky, err_count); else passed++;
        bus_idle(); tick();
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_clean_transfers();
        test_addr_change();
        test_clear_and_timeout();
        test_multi_rule();
        test_saturation();
        test_reset_midxfer();
        test_slverr();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
